fifo_drain_reader: RTL

Read-side master for the 8-deep, 32-bit synchronous FIFO. It pulls words out of the FIFO whenever data is present and there is space downstream. It then presents those words on a valid/ready stream, framing them into fixed-length bursts with a `m_last` marker. It sits between the FIFO's read port and the downstream consumer, and hides the FIFO's one-cycle read latency behind a 2-entry skid buffer.

---
 rtl/fifo_drain_reader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_drain_reader.sv
// Read-side master for the 8x32 synchronous FIFO: issues pops, absorbs the one-cycle
// read latency in a 2-entry skid buffer and frames the output stream into fixed bursts.
module fifo_drain_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty_n,
    output logic                  fifo_read_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           word_count,
    output logic                  busy
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BEAT_W = 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]      word_count_q, word_count_d;

    logic                  pop;
    logic [2:0]            pending;
    logic [1:0]            occ_after_pop;

    // Read issue: only when the buffer can still absorb everything already committed.
    always_comb begin
        pop          = (occ_q != 2'd0) && m_ready;
        pending      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        fifo_read_en = enable && fifo_empty_n && (state_q == RUN) && (pending < 3'd2);
    end

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        occ_d         = occ_q;
        inflight_d    = fifo_read_en;
        beat_cnt_d    = beat_cnt_q;
        word_count_d  = word_count_q;
        occ_after_pop = occ_q - 2'(pop);

        if (pop) begin
            head_d       = tail_q;
            word_count_d = word_count_q + CNT_W'(1);
            beat_cnt_d   = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BEAT_W'(1);
        end

        // Returning word lands behind whatever survives this cycle's pop.
        if (inflight_q) begin
            if (occ_after_pop == 2'd0) begin
                head_d = fifo_data;
            end else begin
                tail_d = fifo_data;
            end
            occ_d = occ_after_pop + 2'd1;
        end else begin
            occ_d = occ_after_pop;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = ((occ_q != 2'd0) || inflight_q) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            beat_cnt_q   <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            beat_cnt_q   <= beat_cnt_d;
            word_count_q <= word_count_d;
        end
    end

    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = head_q;
    assign m_last     = (beat_cnt_q == LAST_BEAT);
    assign word_count = word_count_q;
    assign busy       = (state_q != IDLE);

endmodule
